// File: rtl/aos_softreg_router_pkg.sv
// ----------------------------------------------------------------------------
// aos_softreg_router_pkg
// Shared types and helpers for the SoftReg router and its read tracker.
//   SoftRegReq / SoftRegResp : host and app SoftReg channel structs
//   aos_sr_req_ent_t          : request buffer entry (request without valid)
//   aos_sr_tag_t              : outstanding-read tag {err, idx}
//   AOS_SR_ERR_DATA           : default data returned on error responses
//   aos_sr_app_idx_w()        : width of the app-index address field
//   aos_sr_strip_idx()        : removes the app-index field from an address
//   aos_sr_sat_add16()        : saturating add for the 16-bit statistics
// ----------------------------------------------------------------------------
package aos_softreg_router_pkg;

  typedef struct packed {
    logic        valid;
    logic        isWrite;
    logic [31:0] addr;
    logic [63:0] data;
  } SoftRegReq;

  typedef struct packed {
    logic        valid;
    logic [63:0] data;
  } SoftRegResp;

  typedef struct packed {
    logic        isWrite;
    logic [31:0] addr;
    logic [63:0] data;
  } aos_sr_req_ent_t;

  typedef struct packed {
    logic       err;
    logic [7:0] idx;
  } aos_sr_tag_t;

  localparam logic [63:0] AOS_SR_ERR_DATA = 64'hDEAD_BEEF_DEAD_BEEF;

  // A single app still gets a 1-bit field so idx = 1 can be rejected.
  function automatic int aos_sr_app_idx_w(input int num_apps);
    return (num_apps <= 2) ? 1 : $clog2(num_apps);
  endfunction

  // Bits below lsb stay in place, bits above the field shift down by w and
  // the top w bits fill with zero.
  function automatic logic [31:0] aos_sr_strip_idx(input logic [31:0] addr,
                                                   input int          lsb,
                                                   input int          w);
    logic [31:0] low_mask;
    logic [31:0] upper;
    low_mask = (32'd1 << lsb) - 32'd1;
    upper    = (addr >> (lsb + w)) << lsb;
    return upper | (addr & low_mask);
  endfunction

  function automatic logic [15:0] aos_sr_sat_add16(input logic [15:0] a,
                                                   input logic [8:0]  b);
    logic [16:0] sum;
    sum = {1'b0, a} + {8'd0, b};
    return sum[16] ? 16'hFFFF : sum[15:0];
  endfunction

endpackage

// File: rtl/aos_softreg_router_read_tracker.sv
// ----------------------------------------------------------------------------
// aos_sr_read_tracker
// In-order FIFO of outstanding read tags. The head tag is resolved each cycle
// by an error tag, a disabled app, the app's response, or the head timeout.
// Responses that do not belong to the head read are counted as stray.
//   clk_i, rst_i      : clock, synchronous active-high reset
//   push_i/push_tag_i : new read tag (caller only pushes when push_ready_o)
//   push_ready_o      : room for a tag this cycle (includes same-cycle pop)
//   app_enable_i      : per-app enable mask
//   app_resp_i        : per-app SoftReg responses
//   host_resp_o       : registered host read response, 1-cycle valid
//   stat_timeouts_o   : saturating count of reads answered by timeout
//   stat_stray_o      : saturating count of discarded app responses
// ----------------------------------------------------------------------------
module aos_sr_read_tracker
  import aos_softreg_router_pkg::*;
#(
  parameter int          NUM_APPS       = 4,
  parameter int          MAX_RD_LOG     = 2,
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter logic [63:0] ERR_DATA       = AOS_SR_ERR_DATA
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                push_i,
  input  aos_sr_tag_t         push_tag_i,
  output logic                push_ready_o,
  input  logic [NUM_APPS-1:0] app_enable_i,
  input  SoftRegResp          app_resp_i [NUM_APPS],
  output SoftRegResp          host_resp_o,
  output logic [15:0]         stat_timeouts_o,
  output logic [15:0]         stat_stray_o
);

  localparam int          DEPTH = 1 << MAX_RD_LOG;
  localparam int          PTR_W = (MAX_RD_LOG < 1) ? 1 : MAX_RD_LOG;
  localparam logic [31:0] TMO   = 32'(TIMEOUT_CYCLES);

  aos_sr_tag_t          tag_mem_q [DEPTH];
  logic [PTR_W-1:0]     wr_q, rd_q;
  logic [MAX_RD_LOG:0]  cnt_q;
  logic [31:0]          timer_q;
  SoftRegResp           resp_q, resp_d;
  logic [15:0]          timeouts_q, stray_q;

  aos_sr_tag_t  head;
  logic         empty, full, pop, timeout_hit, consumed;
  logic         head_en, head_rsp_valid;
  logic [63:0]  head_rsp_data;
  logic [255:0] en_ext, rsp_valid_ext;
  logic [8:0]   stray_cnt;

  assign empty = (cnt_q == '0);
  assign full  = (cnt_q == (MAX_RD_LOG+1)'(DEPTH));
  assign head  = tag_mem_q[rd_q];

  assign en_ext  = 256'(app_enable_i);
  assign head_en = en_ext[head.idx];

  always_comb begin
    rsp_valid_ext = '0;
    head_rsp_data = '0;
    for (int i = 0; i < NUM_APPS; i++) begin
      rsp_valid_ext[8'(i)] = app_resp_i[i].valid;
      if (head.idx == 8'(i)) head_rsp_data = app_resp_i[i].data;
    end
  end
  assign head_rsp_valid = rsp_valid_ext[head.idx];

  // Resolution priority: error/disabled first, then a real response, then
  // the timeout, so a response landing on the expiry cycle still wins.
  always_comb begin
    pop         = 1'b0;
    timeout_hit = 1'b0;
    resp_d      = '0;
    if (!empty) begin
      if (head.err || !head_en) begin
        pop    = 1'b1;
        resp_d = '{valid: 1'b1, data: ERR_DATA};
      end else if (head_rsp_valid) begin
        pop    = 1'b1;
        resp_d = '{valid: 1'b1, data: head_rsp_data};
      end else if ((TIMEOUT_CYCLES != 0) && (timer_q == '0)) begin
        pop         = 1'b1;
        timeout_hit = 1'b1;
        resp_d      = '{valid: 1'b1, data: ERR_DATA};
      end
    end
  end

  assign consumed = !empty && !head.err && head_en && head_rsp_valid;

  always_comb begin
    stray_cnt = '0;
    for (int i = 0; i < NUM_APPS; i++) begin
      if (app_resp_i[i].valid && !(consumed && (head.idx == 8'(i))))
        stray_cnt = stray_cnt + 9'd1;
    end
  end

  assign push_ready_o = !full || pop;

  always_ff @(posedge clk_i) begin
    if (push_i) tag_mem_q[wr_q] <= push_tag_i;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_q       <= '0;
      rd_q       <= '0;
      cnt_q      <= '0;
      timer_q    <= TMO;
      resp_q     <= '0;
      timeouts_q <= '0;
      stray_q    <= '0;
    end else begin
      if (push_i) wr_q <= (wr_q == PTR_W'(DEPTH-1)) ? '0 : wr_q + 1'b1;
      if (pop)    rd_q <= (rd_q == PTR_W'(DEPTH-1)) ? '0 : rd_q + 1'b1;
      cnt_q <= cnt_q + (MAX_RD_LOG+1)'(push_i) - (MAX_RD_LOG+1)'(pop);
      // The timer idles at full scale and only runs while a read is at the
      // head, so every new head starts with the whole window.
      if (pop)                           timer_q <= TMO;
      else if (!empty && timer_q != '0) timer_q <= timer_q - 32'd1;
      resp_q     <= resp_d;
      timeouts_q <= aos_sr_sat_add16(timeouts_q, {8'd0, timeout_hit});
      stray_q    <= aos_sr_sat_add16(stray_q, stray_cnt);
    end
  end

  assign host_resp_o     = resp_q;
  assign stat_timeouts_o = timeouts_q;
  assign stat_stray_o    = stray_q;

endmodule

// File: rtl/aos_softreg_router.sv
// ----------------------------------------------------------------------------
// aos_softreg_router
// Single-level SoftReg router from the shell to NUM_APPS app ports. Host
// requests are buffered, decoded at the buffer head and dispatched one per
// cycle; reads are tracked in order so host responses keep request order.
//   clk, rst          : clock, synchronous active-high reset
//   app_enable        : per-app enable mask
//   softreg_req       : host request in
//   softreg_resp      : host response out (registered)
//   app_softreg_req   : per-app requests out (registered, 1-cycle valid)
//   app_softreg_resp  : per-app responses in
//   stat_dropped      : requests dropped (buffer full / write to bad target)
//   stat_timeouts     : reads answered by timeout
//   stat_stray        : app responses not matching the head read
// ----------------------------------------------------------------------------
module aos_softreg_router
  import aos_softreg_router_pkg::*;
#(
  parameter int          NUM_APPS           = 4,
  parameter int          ROUTE_LSB          = 3,
  parameter int          REQ_FIFO_LOG_DEPTH = 2,
  parameter int          MAX_RD_LOG         = 2,
  parameter int unsigned TIMEOUT_CYCLES     = 1024,
  parameter logic [63:0] ERR_DATA           = AOS_SR_ERR_DATA
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_APPS-1:0] app_enable,
  input  SoftRegReq           softreg_req,
  output SoftRegResp          softreg_resp,
  output SoftRegReq           app_softreg_req  [NUM_APPS],
  input  SoftRegResp          app_softreg_resp [NUM_APPS],
  output logic [15:0]         stat_dropped,
  output logic [15:0]         stat_timeouts,
  output logic [15:0]         stat_stray
);

  localparam int APP_IDX_W = aos_sr_app_idx_w(NUM_APPS);
  localparam int REQ_DEPTH = 1 << REQ_FIFO_LOG_DEPTH;
  localparam int RPTR_W    = (REQ_FIFO_LOG_DEPTH < 1) ? 1 : REQ_FIFO_LOG_DEPTH;

  // Request buffer
  aos_sr_req_ent_t             rbuf_q [REQ_DEPTH];
  logic [RPTR_W-1:0]           rwr_q, rrd_q;
  logic [REQ_FIFO_LOG_DEPTH:0] rcnt_q;
  logic                        rfull, rempty, enq, deq, in_drop;

  assign rfull   = (rcnt_q == (REQ_FIFO_LOG_DEPTH+1)'(REQ_DEPTH));
  assign rempty  = (rcnt_q == '0);
  assign enq     = softreg_req.valid && !rfull;
  assign in_drop = softreg_req.valid && rfull;

  always_ff @(posedge clk) begin
    if (enq) rbuf_q[rwr_q] <= '{isWrite: softreg_req.isWrite,
                                addr:    softreg_req.addr,
                                data:    softreg_req.data};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rwr_q  <= '0;
      rrd_q  <= '0;
      rcnt_q <= '0;
    end else begin
      if (enq) rwr_q <= (rwr_q == RPTR_W'(REQ_DEPTH-1)) ? '0 : rwr_q + 1'b1;
      if (deq) rrd_q <= (rrd_q == RPTR_W'(REQ_DEPTH-1)) ? '0 : rrd_q + 1'b1;
      rcnt_q <= rcnt_q + (REQ_FIFO_LOG_DEPTH+1)'(enq)
                       - (REQ_FIFO_LOG_DEPTH+1)'(deq);
    end
  end

  // Head decode
  aos_sr_req_ent_t        head;
  logic [APP_IDX_W-1:0]   head_idx;
  logic [7:0]             head_idx8;
  logic [255:0]           en_ext;
  logic                   head_ok;
  SoftRegReq              fwd;

  assign head      = rbuf_q[rrd_q];
  assign head_idx  = head.addr[ROUTE_LSB +: APP_IDX_W];
  assign head_idx8 = 8'(head_idx);
  assign en_ext    = 256'(app_enable);
  assign head_ok   = (int'(head_idx8) < NUM_APPS) && en_ext[head_idx8];
  assign fwd       = '{valid:   1'b1,
                       isWrite: head.isWrite,
                       addr:    aos_sr_strip_idx(head.addr, ROUTE_LSB, APP_IDX_W),
                       data:    head.data};

  // Dispatch
  logic        trk_push, trk_ready, fwd_valid, inv_drop;
  aos_sr_tag_t push_tag;

  assign push_tag = '{err: !head_ok, idx: head_idx8};

  // A read blocked on a full tracker holds the head, so any writes queued
  // behind it wait too and host ordering is preserved.
  always_comb begin
    deq       = 1'b0;
    trk_push  = 1'b0;
    fwd_valid = 1'b0;
    inv_drop  = 1'b0;
    if (!rempty) begin
      if (head.isWrite) begin
        deq = 1'b1;
        if (head_ok) fwd_valid = 1'b1;
        else         inv_drop  = 1'b1;
      end else if (trk_ready) begin
        deq       = 1'b1;
        trk_push  = 1'b1;
        fwd_valid = head_ok;
      end
    end
  end

  SoftRegReq   app_req_q [NUM_APPS];
  logic [15:0] dropped_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_APPS; i++) app_req_q[i] <= '0;
      dropped_q <= '0;
    end else begin
      for (int i = 0; i < NUM_APPS; i++)
        app_req_q[i] <= (fwd_valid && (head_idx8 == 8'(i))) ? fwd : '0;
      dropped_q <= aos_sr_sat_add16(dropped_q,
                                    {8'd0, in_drop} + {8'd0, inv_drop});
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_APPS; i++) app_softreg_req[i] = app_req_q[i];
  end
  assign stat_dropped = dropped_q;

  aos_sr_read_tracker #(
    .NUM_APPS       (NUM_APPS),
    .MAX_RD_LOG     (MAX_RD_LOG),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .ERR_DATA       (ERR_DATA)
  ) u_read_tracker (
    .clk_i           (clk),
    .rst_i           (rst),
    .push_i          (trk_push),
    .push_tag_i      (push_tag),
    .push_ready_o    (trk_ready),
    .app_enable_i    (app_enable),
    .app_resp_i      (app_softreg_resp),
    .host_resp_o     (softreg_resp),
    .stat_timeouts_o (stat_timeouts),
    .stat_stray_o    (stat_stray)
  );

endmodule

// File: tb/tb_aos_softreg_router.sv
module tb_aos_softreg_router;
  import aos_softreg_router_pkg::*;

  localparam int          N   = 3;
  localparam logic [63:0] ERR = 64'hDEAD_BEEF_DEAD_BEEF;

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  app_enable;
  SoftRegReq     softreg_req;
  SoftRegResp    softreg_resp;
  SoftRegReq     app_req  [N];
  SoftRegResp    app_resp [N];
  logic [15:0]   st_drop, st_to, st_stray;

  always #5 clk = ~clk;

  aos_softreg_router #(
    .NUM_APPS           (N),
    .ROUTE_LSB          (3),
    .REQ_FIFO_LOG_DEPTH (2),
    .MAX_RD_LOG         (2),
    .TIMEOUT_CYCLES     (16),
    .ERR_DATA           (ERR)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .app_enable       (app_enable),
    .softreg_req      (softreg_req),
    .softreg_resp     (softreg_resp),
    .app_softreg_req  (app_req),
    .app_softreg_resp (app_resp),
    .stat_dropped     (st_drop),
    .stat_timeouts    (st_to),
    .stat_stray       (st_stray)
  );

  int cyc = 0;
  always @(posedge clk) cyc++;

  // Observation logs, sampled on the falling edge
  int          app_cnt  [N];
  int          app_cyc  [N];
  logic [31:0] app_addr [N];
  logic [63:0] app_data [N];
  logic        app_wr   [N];
  logic [63:0] h_data [$];
  int          h_cyc  [$];

  always @(negedge clk) begin
    for (int i = 0; i < N; i++) begin
      if (app_req[i].valid) begin
        app_cnt[i]++;
        app_cyc[i]  = cyc;
        app_addr[i] = app_req[i].addr;
        app_data[i] = app_req[i].data;
        app_wr[i]   = app_req[i].isWrite;
      end
    end
    if (softreg_resp.valid) begin
      h_data.push_back(softreg_resp.data);
      h_cyc.push_back(cyc);
    end
  end

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic goto(input int c);
    while (cyc < c) tick();
  endtask

  task automatic send(input logic wr, input logic [31:0] addr,
                      input logic [63:0] data, output int t);
    t = cyc;
    softreg_req = '{valid: 1'b1, isWrite: wr, addr: addr, data: data};
    tick();
    softreg_req = '0;
  endtask

  task automatic respond(input int i, input logic [63:0] data);
    app_resp[i] = '{valid: 1'b1, data: data};
    tick();
    app_resp[i] = '0;
  endtask

  task automatic clear_logs();
    for (int i = 0; i < N; i++) begin
      app_cnt[i] = 0; app_cyc[i] = 0; app_addr[i] = '0;
      app_data[i] = '0; app_wr[i] = 1'b0;
    end
    h_data.delete();
    h_cyc.delete();
  endtask

  function automatic logic [63:0] hd(input int i);
    return (h_data.size() > i) ? h_data[i] : 64'hFFFF_FFFF_FFFF_FFFF;
  endfunction

  function automatic int hc(input int i);
    return (h_cyc.size() > i) ? h_cyc[i] : -1;
  endfunction

  function automatic logic any_app_valid();
    logic v;
    v = 1'b0;
    for (int i = 0; i < N; i++) v = v | app_req[i].valid;
    return v;
  endfunction

  initial begin
    int t, t0, tx;
    rst         = 1'b1;
    app_enable  = 3'b111;
    softreg_req = '0;
    for (int i = 0; i < N; i++) app_resp[i] = '0;
    clear_logs();
    repeat (3) tick();

    chk("rst_resp_valid", 64'(softreg_resp.valid), 0);
    chk("rst_app_valid",  64'(any_app_valid()), 0);
    chk("rst_dropped",    64'(st_drop), 0);
    chk("rst_timeouts",   64'(st_to), 0);
    chk("rst_stray",      64'(st_stray), 0);
    rst = 1'b0;
    tick();

    // Write to app 2, addr 0x10 -> forwarded addr 0 at T+2
    clear_logs();
    send(1'b1, 32'h0000_0010, 64'hA5A5_0000_1234_5678, t);
    goto(t + 5);
    chk("wr_app2_cnt",  64'(app_cnt[2]), 1);
    chk("wr_app2_cyc",  64'(app_cyc[2]), 64'(t + 2));
    chk("wr_app2_addr", 64'(app_addr[2]), 64'h0);
    chk("wr_app2_data", app_data[2], 64'hA5A5_0000_1234_5678);
    chk("wr_app2_isw",  64'(app_wr[2]), 1);
    chk("wr_idle_apps", 64'(app_cnt[0] + app_cnt[1]), 0);
    chk("wr_no_hresp",  64'(h_data.size()), 0);

    // Read app 1 at addr 0x0C (low bits 4 kept); app answers 3 cycles later
    clear_logs();
    send(1'b0, 32'h0000_000C, 64'h0, t);
    goto(t + 5);
    respond(1, 64'h1234);
    goto(t + 9);
    chk("rd1_app_cnt",  64'(app_cnt[1]), 1);
    chk("rd1_app_cyc",  64'(app_cyc[1]), 64'(t + 2));
    chk("rd1_app_addr", 64'(app_addr[1]), 64'h4);
    chk("rd1_app_isw",  64'(app_wr[1]), 0);
    chk("rd1_hresp_n",  64'(h_data.size()), 1);
    chk("rd1_hresp_d",  hd(0), 64'h1234);
    chk("rd1_hresp_c",  64'(hc(0)), 64'(t + 6));

    // Reads to app 0 then app 1; app 1 answers first (stray)
    clear_logs();
    send(1'b0, 32'h0000_0000, 64'h0, t0);
    send(1'b0, 32'h0000_0008, 64'h0, tx);
    goto(t0 + 4);
    respond(1, 64'h1111);
    chk("ooo_stray", 64'(st_stray), 1);
    goto(t0 + 6);
    respond(0, 64'h2222);
    goto(t0 + 26);
    chk("ooo_hresp_n",  64'(h_data.size()), 2);
    chk("ooo_first_d",  hd(0), 64'h2222);
    chk("ooo_first_c",  64'(hc(0)), 64'(t0 + 7));
    chk("ooo_second_d", hd(1), ERR);
    chk("ooo_second_c", 64'(hc(1)), 64'(t0 + 24));
    chk("ooo_timeouts", 64'(st_to), 1);
    chk("ooo_stray2",   64'(st_stray), 1);

    // Silent app 2: ERR at T+19, then a late response is stray
    clear_logs();
    send(1'b0, 32'h0000_0010, 64'h0, t);
    goto(t + 21);
    chk("tmo_hresp_n", 64'(h_data.size()), 1);
    chk("tmo_hresp_d", hd(0), ERR);
    chk("tmo_hresp_c", 64'(hc(0)), 64'(t + 19));
    chk("tmo_count",   64'(st_to), 2);
    respond(2, 64'h77);
    goto(t + 23);
    chk("late_stray",   64'(st_stray), 2);
    chk("late_no_resp", 64'(h_data.size()), 1);

    // Out-of-range idx 3 and disabled app 1 -> two ERR responses in order
    app_enable = 3'b101;
    tick();
    clear_logs();
    send(1'b0, 32'h0000_0018, 64'h0, t);
    send(1'b0, 32'h0000_0008, 64'h0, tx);
    goto(t + 7);
    chk("inv_hresp_n", 64'(h_data.size()), 2);
    chk("inv_first_d", hd(0), ERR);
    chk("inv_first_c", 64'(hc(0)), 64'(t + 3));
    chk("inv_second_d", hd(1), ERR);
    chk("inv_second_c", 64'(hc(1)), 64'(t + 4));
    chk("inv_no_app", 64'(app_cnt[0] + app_cnt[1] + app_cnt[2]), 0);
    chk("inv_timeouts", 64'(st_to), 2);
    send(1'b1, 32'h0000_0008, 64'h55, t);
    goto(t + 4);
    chk("inv_wr_drop", 64'(st_drop), 1);
    chk("inv_wr_noapp", 64'(app_cnt[1]), 0);

    // Fill tracker (4 reads) and buffer (4 more); 9th request is dropped
    app_enable = 3'b111;
    tick();
    clear_logs();
    send(1'b0, 32'h0, 64'h0, t0);
    for (int k = 1; k < 9; k++) send(1'b0, 32'h0, 64'h0, tx);
    goto(t0 + 10);
    chk("fill_app0_cnt", 64'(app_cnt[0]), 4);
    chk("fill_dropped",  64'(st_drop), 2);
    chk("fill_no_hresp", 64'(h_data.size()), 0);

    // Reset mid-flight
    rst = 1'b1;
    tick();
    chk("mrst_resp_valid", 64'(softreg_resp.valid), 0);
    chk("mrst_app_valid",  64'(any_app_valid()), 0);
    chk("mrst_dropped",    64'(st_drop), 0);
    chk("mrst_timeouts",   64'(st_to), 0);
    chk("mrst_stray",      64'(st_stray), 0);
    rst = 1'b0;
    clear_logs();
    tick();
    respond(0, 64'h99);
    chk("post_rst_stray", 64'(st_stray), 1);
    goto(t0 + 45);
    chk("post_rst_no_hresp", 64'(h_data.size()), 0);
    chk("post_rst_no_tmo",   64'(st_to), 0);
    chk("post_rst_no_app",   64'(app_cnt[0] + app_cnt[1] + app_cnt[2]), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
